// File: rtl/mux2_arb.sv
// Round-robin arbiter with burst limit driving the 4-phase control channel of a mux2.
// All asynchronous inputs are synchronized; a post-handshake gap masks stale requests.
module mux2_arb #(
    parameter int unsigned SYNC  = 2,
    parameter int unsigned BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    output logic rctl_o,
    output logic dctl_o,
    input  logic actl_i,
    output logic busy_o,
    output logic last_o
);

    localparam logic [3:0] BurstCnt = 4'(BURST);
    localparam logic [2:0] GapLoad  = 3'(SYNC + 1);

    typedef enum logic [1:0] {StIdle, StReq, StRtz, StGap} state_e;

    state_e          state_q, state_d;
    logic [SYNC-1:0] sync0_q, sync1_q, synca_q;
    logic            s0, s1, sa;
    logic            rctl_q, rctl_d;
    logic            dctl_q, dctl_d;
    logic            busy_q, busy_d;
    logic            last_q, last_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      gap_q, gap_d;
    logic            pick;

    assign s0 = sync0_q[SYNC-1];
    assign s1 = sync1_q[SYNC-1];
    assign sa = synca_q[SYNC-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
            synca_q <= '0;
        end else begin
            sync0_q <= {sync0_q[SYNC-2:0], req0_i};
            sync1_q <= {sync1_q[SYNC-2:0], req1_i};
            synca_q <= {synca_q[SYNC-2:0], actl_i};
        end
    end

    // cnt_q==0 only out of reset: no history yet, so the tie goes against last_q (channel 0).
    always_comb begin
        pick = s1;
        if (s0 && s1) begin
            pick = (cnt_q != 4'd0 && cnt_q < BurstCnt) ? last_q : ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        rctl_d  = rctl_q;
        dctl_d  = dctl_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (s0 || s1) begin
                    dctl_d  = pick;
                    rctl_d  = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (sa) begin
                    rctl_d  = 1'b0;
                    state_d = StRtz;
                end
            end
            StRtz: begin
                if (!sa) begin
                    if (dctl_q == last_q) begin
                        cnt_d = (cnt_q < BurstCnt) ? cnt_q + 4'd1 : cnt_q;
                    end else begin
                        cnt_d = 4'd1;
                    end
                    last_d  = dctl_q;
                    gap_d   = GapLoad;
                    state_d = StGap;
                end
            end
            StGap: begin
                gap_d = gap_q - 3'd1;
                if (gap_q == 3'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rctl_q  <= 1'b0;
            dctl_q  <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            gap_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rctl_q  <= rctl_d;
            dctl_q  <= dctl_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    assign rctl_o = rctl_q;
    assign dctl_o = dctl_q;
    assign busy_o = busy_q;
    assign last_o = last_q;

endmodule
